pipe_hazard_ctrl: RTL and testbench

- Sequencing controller for the ID/EX pipeline register and its neighbours (PC, IF/ID, EX/MEM) in the 5-stage MIPS pipeline.
- Generates per-cycle write-enable and flush controls from several sources: load-use hazards, the multi-cycle multiply/divide unit (MDU), taken branches/jumps resolved in EX, and data-memory wait requests.
- Its idex_we/idex_flush outputs drive the ID/EX register's write-enable and synchronous clear inputs directly.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM).
// Latency: enables/flushes are combinational from state + inputs; md_busy/md_done/mem_err registered.
// Backpressure: mem_stall freezes every stage; branch > MDU dependency > load-use bubble otherwise.
//
// Ports: clk, rst_n (sync, active-low); ID fields id_rs/id_rt/id_use_rs/id_use_rt/id_md_use;
//        EX fields ex_memread/ex_rt/ex_md_start/ex_br_taken; mem_stall from data memory.
//        Outputs: pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, md_busy, md_done, mem_err.
// Optional: define PIPE_HAZARD_PERF_EN to add stall_cyc, flush_cnt and md_stall_cyc counters.
module pipe_hazard_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_md_use,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_md_start,
    input  logic             ex_br_taken,
    input  logic             mem_stall,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             md_busy,
    output logic             md_done,
    output logic             mem_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cyc,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] md_stall_cyc
`endif
);

    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

    localparam logic [7:0]  MD_INIT  = 8'(MD_CYCLES - 1);
    localparam logic [15:0] WAIT_LIM = 16'(TIMEOUT - 1);

    md_state_t   md_state;
    logic [7:0]  md_cnt;
    logic [15:0] wait_cnt;

    logic load_use;
    logic md_dep;
    logic br_hon;      // branch actually acted on this cycle
    logic md_stall_hon; // MDU dependency bubble actually inserted this cycle

    assign md_busy  = (md_state == MD_BUSY);
    assign md_dep   = md_busy && id_md_use;
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_flush   = 1'b0;
        exmem_we     = 1'b1;
        br_hon       = 1'b0;
        md_stall_hon = 1'b0;
        if (!rst_n) begin
            // Every pipeline register clears on the same edge as the controller.
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_stall) begin
            // Full freeze: a pending branch stays in EX and acts after release.
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            br_hon     = 1'b1;
        end else if (md_dep || load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX.
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_flush   = 1'b1;
            md_stall_hon = md_dep;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_state <= MD_IDLE;
            md_cnt   <= 8'd0;
            wait_cnt <= 16'd0;
            md_done  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            md_done <= 1'b0;

            if (mem_stall) begin
                if (wait_cnt != 16'hFFFF) begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                if (wait_cnt >= WAIT_LIM) begin
                    mem_err <= 1'b1;
                end
            end else begin
                wait_cnt <= 16'd0;
            end

            // A start while busy restarts the count and drops the old result.
            if (ex_md_start && !mem_stall) begin
                md_state <= MD_BUSY;
                md_cnt   <= MD_INIT;
            end else if (md_state == MD_BUSY) begin
                if (md_cnt == 8'd0) begin
                    md_state <= MD_IDLE;
                    md_done  <= 1'b1;
                end else begin
                    md_cnt <= md_cnt - 8'd1;
                end
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cyc    <= '0;
            flush_cnt    <= '0;
            md_stall_cyc <= '0;
        end else begin
            if (!pc_we) begin
                stall_cyc <= stall_cyc + 1'b1;
            end
            if (br_hon) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (md_stall_hon) begin
                md_stall_cyc <= md_stall_cyc + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_CYCLES=4, TIMEOUT=5).
// Inputs driven on negedge; outputs sampled 1ns later, so registered outputs reflect the previous posedge.
// Control vector ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we}.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rs, id_use_rt, id_md_use;
    logic       ex_memread, ex_md_start, ex_br_taken, mem_stall;
    logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we;
    logic       md_busy, md_done, mem_err;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [5:0] C_DEF = 6'b110101;
    localparam logic [5:0] C_RST = 6'b011111;
    localparam logic [5:0] C_BUB = 6'b000111;
    localparam logic [5:0] C_BR  = 6'b111111;
    localparam logic [5:0] C_FRZ = 6'b000000;

    wire [5:0] ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_CYCLES(4), .TIMEOUT(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_md_use(id_md_use), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_md_start(ex_md_start), .ex_br_taken(ex_br_taken), .mem_stall(mem_stall),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
        .idex_flush(idex_flush), .exmem_we(exmem_we),
        .md_busy(md_busy), .md_done(md_done), .mem_err(mem_err)
    );

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_md_use = 1'b0;
        ex_memread = 1'b0; ex_md_start = 1'b0; ex_br_taken = 1'b0; mem_stall = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            vectors++;
            if (ctl !== C_RST) begin
                miscompares++;
                $display("FAIL reset_ctl cyc%0d: got %b want %b", c, ctl, C_RST);
            end
        end
        vectors++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || mem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b err=%b want 000", md_busy, md_done, mem_err);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        vectors++;
        if (ctl !== C_DEF) begin
            miscompares++;
            $display("FAIL reset_release_ctl: got %b want %b", ctl, C_DEF);
        end
    endtask

    task automatic test_load_use();
        logic       mr  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0] ert [7] = '{5'd8, 5'd8, 5'd0, 5'd9, 5'd9, 5'd5, 5'd31};
        logic [4:0] irs [7] = '{5'd8, 5'd8, 5'd0, 5'd3, 5'd9, 5'd6, 5'd31};
        logic [4:0] irt [7] = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd3, 5'd7, 5'd31};
        logic       urs [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       urt [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [5:0] exp [7] = '{C_BUB, C_DEF, C_DEF, C_BUB, C_DEF, C_DEF, C_BUB};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ex_memread = mr[i]; ex_rt = ert[i]; id_rs = irs[i]; id_rt = irt[i];
            id_use_rs = urs[i]; id_use_rt = urt[i];
            #1;
            vectors++;
            if (ctl !== exp[i]) begin
                miscompares++;
                $display("FAIL load_use v%0d: got %b want %b", i, ctl, exp[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_mdu();
        // Start at cycle 0, dependent instruction appears at cycle 2.
        @(negedge clk); ex_md_start = 1'b1; #1;
        vectors++;
        if (md_busy !== 1'b0 || ctl !== C_DEF) begin
            miscompares++;
            $display("FAIL mdu_start: busy=%b ctl=%b want 0 %b", md_busy, ctl, C_DEF);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            ex_md_start = 1'b0;
            id_md_use = (c >= 2);
            #1;
            vectors++;
            if (md_busy !== (c <= 4) || md_done !== (c == 5) ||
                ctl !== ((c >= 2 && c <= 4) ? C_BUB : C_DEF)) begin
                miscompares++;
                $display("FAIL mdu_dep cyc%0d: busy=%b done=%b ctl=%b want %b %b %b", c,
                         md_busy, md_done, ctl, (c <= 4), (c == 5),
                         ((c >= 2 && c <= 4) ? C_BUB : C_DEF));
            end
        end
        idle_inputs();

        // Independent instruction while busy proceeds.
        @(negedge clk); ex_md_start = 1'b1;
        @(negedge clk); ex_md_start = 1'b0; #1;
        vectors++;
        if (md_busy !== 1'b1 || ctl !== C_DEF) begin
            miscompares++;
            $display("FAIL mdu_nodep: busy=%b ctl=%b want 1 %b", md_busy, ctl, C_DEF);
        end
        repeat (5) @(negedge clk);

        // Restart while busy: old operation never reports done.
        @(negedge clk); ex_md_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            ex_md_start = (c == 2);
            #1;
            vectors++;
            if (md_busy !== (c <= 6) || md_done !== (c == 7)) begin
                miscompares++;
                $display("FAIL mdu_restart cyc%0d: busy=%b done=%b want %b %b", c,
                         md_busy, md_done, (c <= 6), (c == 7));
            end
        end
        idle_inputs();

        // Reset during MDU operation aborts with no done pulse.
        @(negedge clk); ex_md_start = 1'b1;
        @(negedge clk); ex_md_start = 1'b0;
        @(negedge clk); rst_n = 1'b0; #1;
        vectors++;
        if (ctl !== C_RST) begin
            miscompares++;
            $display("FAIL mdu_reset_ctl: got %b want %b", ctl, C_RST);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (md_busy !== 1'b0 || md_done !== 1'b0) begin
                miscompares++;
                $display("FAIL mdu_reset_abort cyc%0d: busy=%b done=%b want 0 0", c, md_busy, md_done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_priority();
        @(negedge clk);
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; ex_br_taken = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_BR) begin
            miscompares++;
            $display("FAIL br_vs_load_use: got %b want %b", ctl, C_BR);
        end
        idle_inputs();
        @(negedge clk); ex_md_start = 1'b1;
        @(negedge clk); ex_md_start = 1'b0; id_md_use = 1'b1; ex_br_taken = 1'b1; #1;
        vectors++;
        if (ctl !== C_BR) begin
            miscompares++;
            $display("FAIL br_vs_mdu: got %b want %b", ctl, C_BR);
        end
        @(negedge clk); ex_br_taken = 1'b0; #1;
        vectors++;
        if (ctl !== C_BUB) begin
            miscompares++;
            $display("FAIL mdu_after_br: got %b want %b", ctl, C_BUB);
        end
        idle_inputs();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mem_freeze();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_stall = 1'b1; ex_br_taken = 1'b1; ex_md_start = (c == 0);
            ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; id_use_rs = 1'b1;
            #1;
            vectors++;
            if (ctl !== C_FRZ) begin
                miscompares++;
                $display("FAIL freeze cyc%0d: got %b want %b", c, ctl, C_FRZ);
            end
        end
        @(negedge clk);
        mem_stall = 1'b0; ex_md_start = 1'b0; #1;
        vectors++;
        if (ctl !== C_BR || md_busy !== 1'b0 || mem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL freeze_release: ctl=%b busy=%b err=%b want %b 0 0", ctl, md_busy, mem_err, C_BR);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        // Two 4-cycle stalls separated by a free cycle never reach the limit.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); mem_stall = (c != 4);
        end
        @(negedge clk); mem_stall = 1'b0; #1;
        vectors++;
        if (mem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_wait_clear: err=%b want 0", mem_err);
        end
        // Sustained stall: error appears after the 5th stalled cycle.
        @(negedge clk); mem_stall = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); #1;
            vectors++;
            if (mem_err !== (k >= 5)) begin
                miscompares++;
                $display("FAIL timeout_stall k=%0d: err=%b want %b", k, mem_err, (k >= 5));
            end
        end
        mem_stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            vectors++;
            if (mem_err !== 1'b1 || ctl !== C_DEF) begin
                miscompares++;
                $display("FAIL timeout_sticky cyc%0d: err=%b ctl=%b want 1 %b", c, mem_err, ctl, C_DEF);
            end
        end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        vectors++;
        if (mem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_reset: err=%b want 0", mem_err);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mdu();
        test_branch_priority();
        test_mem_freeze();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
